// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and address-split widths for dmem_cache
package mem_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  function automatic int index_w(input int nlines);
    return $clog2(nlines);
  endfunction

  function automatic int tag_w(input int nbits, input int nlines);
    return nbits - $clog2(nlines);
  endfunction

endpackage

// File: rtl/backing_store.sv
// rtl/backing_store.sv - single-port synchronous RAM behind the data cache
module backing_store #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_cache.sv
// rtl/dmem_cache.sv - direct-mapped write-through, no-write-allocate data cache
// in front of a fixed-latency backing store; busy stalls the core on misses and writes.
module dmem_cache
  import mem_pkg::*;
#(
  parameter int NBITS        = 8,
  parameter int NLINES       = 8,
  parameter int MISS_LATENCY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy
);

  localparam int IW = index_w(NLINES);
  localparam int TW = tag_w(NBITS, NLINES);
  localparam int CW = $clog2(MISS_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(MISS_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] addr_q, addr_d, data_q, data_d;
  logic [NLINES-1:0] valid_q;
  logic [NBITS-1:0] line_q [NLINES];
  logic [TW-1:0]    ltag_q [NLINES];

  logic [IW-1:0]    req_idx, lat_idx;
  logic [TW-1:0]    req_tag, lat_tag;
  logic             req_hit, lat_hit, fill_en, wr_en;
  logic [NBITS-1:0] store_addr, store_rdata;

  assign req_idx = Address[IW-1:0];
  assign req_tag = Address[NBITS-1:IW];
  assign lat_idx = addr_q[IW-1:0];
  assign lat_tag = addr_q[NBITS-1:IW];
  assign req_hit = valid_q[req_idx] && (ltag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (ltag_q[lat_idx] == lat_tag);

  // Presenting the live address in IDLE makes the RAM output valid from the first FILL cycle.
  assign store_addr = (state_q == IDLE) ? Address : addr_q;

  backing_store #(.AW(NBITS), .DW(NBITS)) u_store (
    .clk_i   (clock),
    .we_i    (wr_en),
    .addr_i  (store_addr),
    .wdata_i (data_q),
    .rdata_o (store_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy     = 1'b0;
    ReadData = '0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          addr_d  = Address;
          data_d  = WriteData;
          cnt_d   = '0;
          state_d = WRITE;
          busy    = 1'b1;
        end else if (MemRead) begin
          if (req_hit) begin
            ReadData = line_q[req_idx];
          end else begin
            addr_d  = Address;
            cnt_d   = '0;
            state_d = FILL;
            busy    = 1'b1;
          end
        end
      end
      FILL, WRITE: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          fill_en = (state_q == FILL);
          wr_en   = (state_q == WRITE);
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (fill_en) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Line payload and tags need no reset; valid_q gates every use of them.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_q[lat_idx] <= store_rdata;
      ltag_q[lat_idx] <= lat_tag;
    end else if (wr_en && lat_hit) begin
      line_q[lat_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// tb/tb_dmem_cache.sv - randomized self-checking bench for dmem_cache against a memory-level model
module tb_dmem_cache;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       MemRead = 1'b0;
  logic       MemWrite = 1'b0;
  logic [7:0] Address = '0;
  logic [7:0] WriteData = '0;
  logic [7:0] ReadData;
  logic       busy;

  dmem_cache #(.NBITS(8), .NLINES(8), .MISS_LATENCY(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic       chk = 1'b0;
  logic       exp_busy = 1'b0;
  logic       dchk = 1'b0;
  logic [7:0] exp_d = '0;
  string      phase = "reset";

  // Model: the full memory image plus which word each line currently holds.
  logic [7:0] st [256];
  bit         mv [8];
  int         mtag [8];

  always @(negedge clock) begin
    if (chk) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy[%s] got %b want %b at %0t", phase, busy, exp_busy, $time);
      end
      if (dchk) begin
        checks++;
        if (ReadData !== exp_d) begin
          errors++;
          $display("FAIL rdata[%s] got %02h want %02h at %0t", phase, ReadData, exp_d, $time);
        end
      end
    end
  end

  task automatic step(input logic b, input logic dc, input logic [7:0] d);
    exp_busy = b;
    dchk     = dc;
    exp_d    = d;
    chk      = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model_lines();
    for (int i = 0; i < 8; i++) mv[i] = 0;
  endtask

  task automatic do_reset();
    phase    = "reset";
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    reset    = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    reset    = 1'b0;
    clear_model_lines();
  endtask

  task automatic idle_cycle();
    phase    = "idle";
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output int nb, output logic [7:0] ed);
    int  idx, tg;
    bit  hit;
    idx = a % 8;
    tg  = a / 8;
    hit = mv[idx] && (mtag[idx] == tg);
    if (wr) begin
      phase = "write";
      nb    = 5;
      ed    = 8'h00;
      st[a] = d;
    end else begin
      phase     = hit ? "read_hit" : "read_miss";
      nb        = hit ? 0 : 5;
      ed        = st[a];
      mv[idx]   = 1;
      mtag[idx] = tg;
    end
    MemRead   = rd;
    MemWrite  = wr;
    Address   = a;
    WriteData = d;
    for (int c = 0; c < nb; c++) step(1'b1, 1'b0, 8'h00);
    if (wr) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      step(1'b0, 1'b1, 8'h00);
    end else begin
      step(1'b0, 1'b1, ed);
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic abort_write(input logic [7:0] a, input logic [7:0] d);
    phase     = "abort";
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    MemWrite  = 1'b0;
    reset     = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    reset     = 1'b0;
    clear_model_lines();
  endtask

  task automatic pin(input string n, input int nb, input int enb,
                     input logic [7:0] ed, input logic [7:0] eed);
    checks++;
    if (nb != enb || ed !== eed) begin
      errors++;
      $display("FAIL pin[%s] got %0d/%02h want %0d/%02h", n, nb, ed, enb, eed);
    end
  endtask

  initial begin
    int         nb;
    logic [7:0] ed;
    logic       rd, wr;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) st[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mv[i]   = 0;
      mtag[i] = 0;
    end
    @(posedge clock);
    #1;
    do_reset();

    access(1, 0, 8'h12, 8'h00, nb, ed); pin("t1_read_miss", nb, 5, ed, 8'h00);
    access(0, 1, 8'h12, 8'hA5, nb, ed); pin("t2_write",     nb, 5, ed, 8'h00);
    access(1, 0, 8'h12, 8'h00, nb, ed); pin("t2_read_hit",  nb, 0, ed, 8'hA5);
    access(1, 0, 8'h22, 8'h00, nb, ed); pin("t3_conflict",  nb, 5, ed, 8'h00);
    access(1, 0, 8'h12, 8'h00, nb, ed); pin("t3_refill",    nb, 5, ed, 8'hA5);

    do_reset();
    access(0, 1, 8'h30, 8'h3C, nb, ed); pin("t4_write",     nb, 5, ed, 8'h00);
    access(1, 0, 8'h30, 8'h00, nb, ed); pin("t4_no_alloc",  nb, 5, ed, 8'h3C);

    abort_write(8'h40, 8'h77);
    access(1, 0, 8'h40, 8'h00, nb, ed); pin("t5_aborted",   nb, 5, ed, 8'h00);

    access(1, 1, 8'h05, 8'h11, nb, ed); pin("t6_both",      nb, 5, ed, 8'h00);
    access(1, 0, 8'h05, 8'h00, nb, ed); pin("t6_read",      nb, 5, ed, 8'h11);
    idle_cycle();

    repeat (400) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_reset();
      end else if (r < 5) begin
        idle_cycle();
      end else begin
        if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
        else a = 8'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
        wr = ($urandom_range(0, 2) == 0);
        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        access(rd, wr, a, 8'($urandom_range(0, 255)), nb, ed);
      end
    end

    chk = 1'b0;
    @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
